// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_func.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__clkdiv_func
//
// Functional model of a programmable, glitch-free clock divider. It sits in
// front of the clock inverter/buffer cells and drives their I pin.
//
// Q is a registered 50%-duty clock. Its high and low phases are each R+1 CLK
// cycles long. A new ratio only takes effect at the end of a low phase. A stop
// request only takes effect at the end of a low phase. Because of this, no
// pulse on Q is ever shortened. The one exception is an asynchronous reset.
//
// Parameters
//   W          width of the ratio field
//   RST_RATIO  ratio loaded into the active ratio register at reset
//
// Ports
//   CLK   in   source clock; all state updates on its rising edge
//   RN    in   asynchronous active-low reset
//   EN    in   run request (level)
//   LD    in   load strobe; DIV is captured on every edge where LD=1
//   DIV   in   requested ratio; output period is 2*(DIV+1) CLK cycles
//   Q     out  divided clock (registered)
//   QN    out  separately registered complement of Q. This port exists
//              only when GF180MCU_FD_SC_MCU9T5V0__CLKDIV_QN_EN is defined.
//   ACK   out  one-cycle pulse when a loaded ratio becomes active
//   BUSY  out  high whenever the divider is not idle
//
// Optional feature macro: GF180MCU_FD_SC_MCU9T5V0__CLKDIV_QN_EN
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_func #(
    parameter int W         = 4,
    parameter int RST_RATIO = 0
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic         EN,
    input  logic         LD,
    input  logic [W-1:0] DIV,
    output logic         Q,
`ifdef GF180MCU_FD_SC_MCU9T5V0__CLKDIV_QN_EN
    output logic         QN,
`endif
    output logic         ACK,
    output logic         BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   p_q, p_d;
    logic           pf_q, pf_d;
    logic           q_q, q_d;
    logic           ack_q, ack_d;

    logic           at_max;
    logic           boundary;

    // The end of a low phase is the only safe point at which the waveform
    // can change. A new ratio or a stop is applied only on this edge.
    assign at_max   = (cnt_q == r_q);
    assign boundary = (state_q != IDLE) && at_max && !q_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        p_d     = p_q;
        pf_d    = pf_q;
        q_d     = q_q;
        ack_d   = 1'b0;

        if (LD) begin
            p_d  = DIV;
            pf_d = 1'b1;
        end

        // A strobe on the apply edge itself bypasses the pending register.
        // This lets a load while idle take effect on the very next edge.
        if ((boundary || state_q == IDLE) && (pf_q || LD)) begin
            r_d   = LD ? DIV : p_q;
            pf_d  = 1'b0;
            ack_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                q_d   = 1'b0;
                if (EN) begin
                    state_d = RUN;
                    q_d     = 1'b1;
                end
            end

            RUN, STOP: begin
                if (at_max) begin
                    cnt_d = '0;
                    q_d   = ~q_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end

                if (state_q == RUN) begin
                    if (!EN) begin
                        state_d = STOP;
                    end
                end else if (EN) begin
                    // A re-request before the period ends resumes the
                    // current waveform as though it had never stopped.
                    state_d = RUN;
                end else if (boundary) begin
                    state_d = IDLE;
                    q_d     = 1'b0;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                q_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= W'(RST_RATIO);
            p_q     <= '0;
            pf_q    <= 1'b0;
            q_q     <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            p_q     <= p_d;
            pf_q    <= pf_d;
            q_q     <= q_d;
            ack_q   <= ack_d;
        end
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0__CLKDIV_QN_EN
    logic qn_q;

    // QN has its own flop rather than an inverter after Q. This keeps the
    // inverting and non-inverting trees aligned with zero skew.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            qn_q <= 1'b1;
        end else begin
            qn_q <= ~q_d;
        end
    end

    assign QN = qn_q;
`endif

    assign Q    = q_q;
    assign ACK  = ack_q;
    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_func.sv
// -----------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_func
//
// Scoreboard bench for the clock divider.
//
// Each stimulus cycle drives the inputs and then queues the hand-computed
// outputs expected after the next rising edge. A separate monitor compares
// those outputs on every falling edge. The asynchronous-reset check is made
// directly, before any clock edge can occur.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_func;

    logic       CLK;
    logic       RN;
    logic       EN;
    logic       LD;
    logic [3:0] DIV;
    logic       Q;
    logic       ACK;
    logic       BUSY;
`ifdef GF180MCU_FD_SC_MCU9T5V0__CLKDIV_QN_EN
    logic       QN;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  q;
        logic  ack;
        logic  busy;
        string tag;
    } exp_t;

    exp_t expQueue[$];

    gf180mcu_fd_sc_mcu9t5v0__clkdiv_func #(
        .W        (4),
        .RST_RATIO(0)
    ) dut (
        .CLK (CLK),
        .RN  (RN),
        .EN  (EN),
        .LD  (LD),
        .DIV (DIV),
        .Q   (Q),
`ifdef GF180MCU_FD_SC_MCU9T5V0__CLKDIV_QN_EN
        .QN  (QN),
`endif
        .ACK (ACK),
        .BUSY(BUSY)
    );

    // 10-unit clock: rising edges at 5, 15, ...; falling edges at 10, 20, ...
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Compare the outputs against one expectation and record the result.
    task automatic checkOutput(input string tag, input logic q, input logic ack,
                               input logic busy);
        logic ok;
        ok = (Q === q) && (ACK === ack) && (BUSY === busy);
`ifdef GF180MCU_FD_SC_MCU9T5V0__CLKDIV_QN_EN
        ok = ok && (QN === ~q);
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got Q=%b ACK=%b BUSY=%b, expected Q=%b ACK=%b BUSY=%b",
                     tag, $time, Q, ACK, BUSY, q, ack, busy);
`ifdef GF180MCU_FD_SC_MCU9T5V0__CLKDIV_QN_EN
            $display("[TB] FAIL %s qn at %0t: got QN=%b expected QN=%b", tag, $time, QN, ~q);
`endif
        end
    endtask

    // Drive one cycle of inputs just after a falling edge. Queue the outputs
    // expected after the rising edge that follows.
    task automatic applyStimulus(input logic rn, input logic en, input logic ld,
                                 input logic [3:0] div, input logic q,
                                 input logic ack, input logic busy,
                                 input string tag);
        exp_t e;
        @(negedge CLK);
        #1;
        RN  = rn;
        EN  = en;
        LD  = ld;
        DIV = div;
        e.q    = q;
        e.ack  = ack;
        e.busy = busy;
        e.tag  = tag;
        expQueue.push_back(e);
    endtask

    // Monitor: the DUT presents a new output set every cycle.
    always @(negedge CLK) begin
        exp_t e;
        if (expQueue.size() > 0) begin
            e = expQueue.pop_front();
            checkOutput(e.tag, e.q, e.ack, e.busy);
        end
    end

    // Stimulus: directed vectors with hand-computed expectations.
    initial begin
        RN  = 1'b0;
        EN  = 1'b1;
        LD  = 1'b0;
        DIV = 4'd0;

        // Reset held with EN=1, then released; R=0 gives a toggle every cycle.
        applyStimulus(0, 1, 0, 4'd0, 0, 0, 0, "reset_hold0");
        applyStimulus(0, 1, 0, 4'd0, 0, 0, 0, "reset_hold1");
        applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "first_rise");
        applyStimulus(1, 1, 0, 4'd0, 0, 0, 1, "r0_low");
        applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "r0_high");
        applyStimulus(1, 1, 0, 4'd0, 0, 0, 1, "r0_low2");
        applyStimulus(1, 0, 0, 4'd0, 1, 0, 1, "r0_stop_high");
        applyStimulus(1, 0, 0, 4'd0, 0, 0, 1, "r0_stop_low");
        applyStimulus(1, 0, 0, 4'd0, 0, 0, 0, "r0_idle");

        // A load in IDLE acknowledges on the next cycle; R=2 runs 3/3.
        applyStimulus(1, 0, 1, 4'd2, 0, 1, 0, "idle_load_ack");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "r2_high");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 4'd0, 0, 0, 1, "r2_low");
        applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "r2_high2_c0");

        // Load R=0 at cnt=1 of the high phase; the current 3/3 period completes.
        applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "r2_high2_c1");
        applyStimulus(1, 1, 1, 4'd0, 1, 0, 1, "midload_hold");
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 4'd0, 0, 0, 1, "midload_low");
        applyStimulus(1, 1, 0, 4'd0, 1, 1, 1, "boundary_ack");
        applyStimulus(1, 1, 0, 4'd0, 0, 0, 1, "new_r0_low");
        applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "new_r0_high");
        applyStimulus(1, 1, 0, 4'd0, 0, 0, 1, "new_r0_low2");

        // Load R=3 on the boundary edge itself, then drop EN at the 2nd high cycle.
        applyStimulus(1, 1, 1, 4'd3, 1, 1, 1, "r3_apply");
        applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "r3_high2");
        applyStimulus(1, 0, 0, 4'd0, 1, 0, 1, "r3_stop_high3");
        applyStimulus(1, 0, 0, 4'd0, 1, 0, 1, "r3_stop_high4");
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 4'd0, 0, 0, 1, "r3_stop_low");
        applyStimulus(1, 0, 0, 4'd0, 0, 0, 0, "r3_busy_fall");
        applyStimulus(1, 0, 0, 4'd0, 0, 0, 0, "r3_idle_hold");

        // Drop EN in the high phase and re-request two cycles later.
        applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "resume_h1");
        applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "resume_h2");
        applyStimulus(1, 0, 0, 4'd0, 1, 0, 1, "resume_h3");
        applyStimulus(1, 0, 0, 4'd0, 1, 0, 1, "resume_h4");
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 4'd0, 0, 0, 1, "resume_low");
        applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "resume_run_h1");
        applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "resume_run_h2");

        // Leave a load pending mid high phase, then reset asynchronously.
        applyStimulus(1, 1, 1, 4'd5, 1, 0, 1, "pending_load");
        @(negedge CLK);
        #1;
        RN = 1'b0;
        LD = 1'b0;
        #1;
        checkOutput("async_reset", 0, 0, 0);
        applyStimulus(0, 1, 0, 4'd0, 0, 0, 0, "reset_mid");
        applyStimulus(1, 0, 0, 4'd0, 0, 0, 0, "pending_discarded");
        applyStimulus(1, 1, 0, 4'd0, 1, 0, 1, "restart_rise");
        applyStimulus(1, 1, 0, 4'd0, 0, 0, 1, "restart_rst_ratio");

        // Let the monitor drain the last expectation.
        @(negedge CLK);
        #1;
        checks++;
        if (expQueue.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0",
                     expQueue.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Time limit so the bench always terminates.
    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL timeout: simulation reached time limit, expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] time limit reached");
    end

endmodule
